// File: rtl/uart_cmd_assembler.sv
// Assembles pairs of UART bytes (high byte first) into 16-bit commands, acking each
// byte to the receiver, with an inter-byte timeout and command-overrun reporting.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy_i,
  input  logic [7:0]  rx_data_i,
  output logic        clr_rx_rdy_o,
  output logic [15:0] cmd_o,
  output logic        cmd_rdy_o,
  input  logic        clr_cmd_rdy_i,
  output logic        busy_o,
  output logic        timeout_err_o,
  output logic        overrun_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(1'b0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1'b1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          overrun_q, overrun_d;
  logic          clr_rx_rdy_s;
  logic          complete_s;

  // Next-state logic: byte acceptance, command completion and timeout
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    timer_d       = timer_q;
    cmd_d         = cmd_q;
    timeout_err_d = 1'b0;
    clr_rx_rdy_s  = 1'b0;
    complete_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_rdy_i) begin
          clr_rx_rdy_s = 1'b1;
          hi_d         = rx_data_i;
          timer_d      = TIMER_INIT;
          state_d      = WAIT_LO;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        // A byte arriving on the last timer cycle still completes the command
        if (rx_rdy_i) begin
          clr_rx_rdy_s = 1'b1;
          complete_s   = 1'b1;
          cmd_d        = {hi_q, rx_data_i};
          hi_d         = 8'h00;
          timer_d      = TIMER_ZERO;
          state_d      = IDLE;
        end else if (timer_q == TIMER_ZERO) begin
          timeout_err_d = 1'b1;
          hi_d          = 8'h00;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        hi_d    = 8'h00;
        timer_d = TIMER_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // Ready flag: completion wins over a simultaneous consumer clear
  always_comb begin
    cmd_rdy_d = cmd_rdy_q;
    overrun_d = complete_s & cmd_rdy_q & ~clr_cmd_rdy_i;
    if (complete_s) begin
      cmd_rdy_d = 1'b1;
    end else if (clr_cmd_rdy_i) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hi_q          <= 8'h00;
      timer_q       <= TIMER_ZERO;
      cmd_q         <= 16'h0000;
      cmd_rdy_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      cmd_rdy_q     <= cmd_rdy_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign clr_rx_rdy_o  = clr_rx_rdy_s;
  assign cmd_o         = cmd_q;
  assign cmd_rdy_o     = cmd_rdy_q;
  assign busy_o        = (state_q == WAIT_LO);
  assign timeout_err_o = timeout_err_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler: a cycle-numbered reference model pushes the
// expected visible outputs per cycle; an independent monitor pops and compares them.
module tb_uart_cmd_assembler;

  localparam int T = 100;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        busy;
  logic        timeout_err;
  logic        overrun;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_rdy_i      (rx_rdy),
    .rx_data_i     (rx_data),
    .clr_rx_rdy_o  (clr_rx_rdy),
    .cmd_o         (cmd),
    .cmd_rdy_o     (cmd_rdy),
    .clr_cmd_rdy_i (clr_cmd_rdy),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .overrun_o     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ack;
    bit          busy;
    bit          rdy;
    logic [15:0] cmd;
    bit          to;
    bit          ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // reference model state: pending high byte and the cycle number it was accepted in
  int          cyc;
  bit          pend;
  int          t_hi;
  logic [7:0]  hi;
  bit          m_rdy;
  logic [15:0] m_cmd;
  bit          ev_to;
  bit          ev_ov;
  int          n_to;
  int          n_ov;
  int          n_cmd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; pend = 1'b0; t_hi = 0; hi = 8'h00;
    m_rdy = 1'b0; m_cmd = 16'h0000; ev_to = 1'b0; ev_ov = 1'b0;
  endtask

  // one clock cycle of stimulus; records what the DUT must show during this cycle
  task automatic step(input bit rx, input logic [7:0] d, input bit clr);
    exp_t e;
    @(posedge clk);
    #1;
    rx_rdy      = rx;
    rx_data     = d;
    clr_cmd_rdy = clr;
    e.ack  = rx;
    e.busy = pend;
    e.rdy  = m_rdy;
    e.cmd  = m_cmd;
    e.to   = ev_to;
    e.ov   = ev_ov;
    exp_q.push_back(e);
    ev_to = 1'b0;
    ev_ov = 1'b0;
    if (rx && pend) begin
      ev_ov = m_rdy && !clr;
      m_cmd = {hi, d};
      m_rdy = 1'b1;
      pend  = 1'b0;
      n_cmd++;
      if (ev_ov) n_ov++;
    end else begin
      if (rx) begin
        pend = 1'b1;
        hi   = d;
        t_hi = cyc;
      end else if (pend && (cyc - t_hi >= T)) begin
        ev_to = 1'b1;
        pend  = 1'b0;
        n_to++;
      end
      if (clr) m_rdy = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input bit clr);
    step(1'b1, b, clr);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", {15'h0000, cmd_rdy}, 16'h0000);
    chk("rst_busy", {15'h0000, busy}, 16'h0000);
    chk("rst_timeout_err", {15'h0000, timeout_err}, 16'h0000);
    chk("rst_overrun", {15'h0000, overrun}, 16'h0000);
    chk("rst_clr_rx_rdy", {15'h0000, clr_rx_rdy}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // monitor: compares every sampled cycle against the model's expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("clr_rx_rdy", {15'h0000, clr_rx_rdy}, {15'h0000, e.ack});
        chk("busy", {15'h0000, busy}, {15'h0000, e.busy});
        chk("cmd_rdy", {15'h0000, cmd_rdy}, {15'h0000, e.rdy});
        chk("cmd", cmd, e.cmd);
        chk("timeout_err", {15'h0000, timeout_err}, {15'h0000, e.to});
        chk("overrun", {15'h0000, overrun}, {15'h0000, e.ov});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    n_to = 0; n_ov = 0; n_cmd = 0;
    rst_n = 1'b0;
    apply_reset();

    // 1: basic pair, then consumer clears
    idle(2);
    send(8'hA5, 1'b0); idle(2); send(8'h3C, 1'b0); idle(3);
    step(1'b0, 8'h00, 1'b1); idle(2);

    // 2: lost low byte times out, next pair is clean
    send(8'h12, 1'b0); idle(T + 2);
    send(8'h55, 1'b0); send(8'h66, 1'b0); idle(2);
    step(1'b0, 8'h00, 1'b1); idle(1);

    // 3: low byte exactly on the last allowed cycle
    send(8'h12, 1'b0); idle(T - 1); send(8'h34, 1'b0); idle(3);
    step(1'b0, 8'h00, 1'b1); idle(1);

    // 4: two commands without consumption
    send(8'h11, 1'b0); send(8'h11, 1'b0); idle(1);
    send(8'h22, 1'b0); send(8'h22, 1'b0); idle(3);

    // 5: consumer clear in the same cycle as the low byte
    send(8'h77, 1'b0); send(8'h88, 1'b1); idle(3);
    step(1'b0, 8'h00, 1'b1); idle(1);

    // 6: reset while holding a high byte
    send(8'hAB, 1'b0); idle(2);
    apply_reset();
    send(8'hCD, 1'b0); send(8'hEF, 1'b0); idle(3);

    // random phase: short and near-timeout gaps, random consumer clears
    for (int k = 0; k < 300; k++) begin
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 3, T + 3)) : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++)
        step(1'b0, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      step(1'b1, 8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
    end
    idle(T + 5);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    if (n_to == 0 || n_ov == 0 || n_cmd < 10)
      $display("note: sparse coverage to=%0d ov=%0d cmd=%0d", n_to, n_ov, n_cmd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
